// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU datapath: sequencer state encoding,
// ALU opcode constants and a counter-width helper.
package uart_alu_pkg;

    localparam int unsigned NB_STATE  = 3;
    localparam int unsigned NB_OPCODE = 6;

    typedef logic [NB_STATE-1:0] state_t;

    localparam state_t WAIT_A  = 3'd0;
    localparam state_t WAIT_B  = 3'd1;
    localparam state_t WAIT_OP = 3'd2;
    localparam state_t EXEC    = 3'd3;
    localparam state_t WAIT_TX = 3'd4;

    localparam logic [NB_OPCODE-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OPCODE-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OPCODE-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OPCODE-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OPCODE-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OPCODE-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OPCODE-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OPCODE-1:0] OP_SRL = 6'b000010;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundle between the sequencer and the rx_uart/tx_uart/ALU datapath.
// master: the sequencer; slave: the datapath side.
interface uart_alu_sequencer_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done_tick;
    logic               i_tx_done_tick;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_data_a;
    logic [NB_DATA-1:0] o_alu_data_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_overrun;
    logic               o_timeout;

    modport master (
        input  i_rx_data, i_rx_done_tick, i_tx_done_tick, i_alu_result,
        output o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data,
               o_tx_start, o_busy, o_overrun, o_timeout
    );

    modport slave (
        output i_rx_data, i_rx_done_tick, i_tx_done_tick, i_alu_result,
        input  o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data,
               o_tx_start, o_busy, o_overrun, o_timeout
    );
endinterface

// File: rtl/uart_alu_gap_timer.sv
// Inter-byte gap counter: cleared by i_clear or while disabled, counts while
// enabled and holds at TICKS-1, where o_expire_c is raised.
module uart_alu_gap_timer
    import uart_alu_pkg::*;
#(
    parameter int unsigned TICKS = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);
    localparam int unsigned NB_CNT = cnt_width(TICKS);

    logic [NB_CNT-1:0] count;

    assign o_expire_c = i_enable && (count == NB_CNT'(TICKS - 1));

    // Gap count register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear || !i_enable) begin
            count <= '0;
        end else if (!o_expire_c) begin
            count <= count + NB_CNT'(1);
        end
    end
endmodule

// File: rtl/uart_alu_sequencer.sv
// Sequencer: collects operand A, operand B and opcode bytes from rx_uart,
// runs them through the ALU and launches one tx_uart transmission of the result.
// Optional inter-byte timeout enabled by macro UART_ALU_SEQ_TIMEOUT_EN.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned NB_OP         = 6,
    parameter int unsigned TIMEOUT_TICKS = 1000000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_alu_sequencer_if.master bus
);
    if (TIMEOUT_TICKS < 2) begin : g_bad_ticks
        $error("TIMEOUT_TICKS must be at least 2");
    end

    state_t             state, state_next;
    logic               settled, settled_next;
    logic [NB_DATA-1:0] data_a, data_a_next;
    logic [NB_DATA-1:0] data_b, data_b_next;
    logic [NB_OP-1:0]   op, op_next;
    logic [NB_DATA-1:0] tx_data, tx_data_next;
    logic               tx_start, tx_start_next;
    logic               busy, busy_next;
    logic               overrun, overrun_next;
    logic               timeout, timeout_next;
    logic               expire_c;

`ifdef UART_ALU_SEQ_TIMEOUT_EN
    logic gap_en_c;
    assign gap_en_c = (state == WAIT_B) || (state == WAIT_OP);

    uart_alu_gap_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_gap_timer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (bus.i_rx_done_tick),
        .i_enable   (gap_en_c),
        .o_expire_c (expire_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= WAIT_A;
            settled  <= 1'b0;
            data_a   <= '0;
            data_b   <= '0;
            op       <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            settled  <= settled_next;
            data_a   <= data_a_next;
            data_b   <= data_b_next;
            op       <= op_next;
            tx_data  <= tx_data_next;
            tx_start <= tx_start_next;
            busy     <= busy_next;
            overrun  <= overrun_next;
            timeout  <= timeout_next;
        end
    end

    // Next state; EXEC spends a full cycle letting the ALU settle before capture
    always_comb begin
        state_next   = state;
        settled_next = 1'b0;
        case (state)
            WAIT_A:  if (bus.i_rx_done_tick) state_next = WAIT_B;
            WAIT_B: begin
                if (bus.i_rx_done_tick) state_next = WAIT_OP;
                else if (expire_c)      state_next = WAIT_A;
            end
            WAIT_OP: begin
                if (bus.i_rx_done_tick) state_next = EXEC;
                else if (expire_c)      state_next = WAIT_A;
            end
            EXEC: begin
                if (settled) state_next   = WAIT_TX;
                else         settled_next = 1'b1;
            end
            WAIT_TX: if (bus.i_tx_done_tick) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        data_a_next   = data_a;
        data_b_next   = data_b;
        op_next       = op;
        tx_data_next  = tx_data;
        tx_start_next = 1'b0;
        overrun_next  = 1'b0;
        timeout_next  = 1'b0;
        busy_next     = (state_next != WAIT_A);
        case (state)
            WAIT_A: if (bus.i_rx_done_tick) data_a_next = bus.i_rx_data;
            WAIT_B: begin
                if (bus.i_rx_done_tick) data_b_next  = bus.i_rx_data;
                else if (expire_c)      timeout_next = 1'b1;
            end
            WAIT_OP: begin
                if (bus.i_rx_done_tick) op_next      = bus.i_rx_data[NB_OP-1:0];
                else if (expire_c)      timeout_next = 1'b1;
            end
            EXEC: begin
                if (settled) begin
                    tx_data_next  = bus.i_alu_result;
                    tx_start_next = 1'b1;
                end
                if (bus.i_rx_done_tick) overrun_next = 1'b1;
            end
            WAIT_TX: if (bus.i_rx_done_tick) overrun_next = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_alu_data_a = data_a;
    assign bus.o_alu_data_b = data_b;
    assign bus.o_alu_op     = op;
    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_start   = tx_start;
    assign bus.o_busy       = busy;
    assign bus.o_overrun    = overrun;
    assign bus.o_timeout    = timeout;
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: directed frames, scoreboard on
// o_tx_start, overrun/timeout pulse counting. Build with UART_ALU_SEQ_TIMEOUT_EN
// to exercise the timeout path (TIMEOUT_TICKS=16).
module tb_uart_alu_sequencer;
    import uart_alu_pkg::*;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
    localparam int unsigned TICKS = 16;
`else
    localparam int unsigned TICKS = 1000000;
`endif

    typedef struct {
        logic [NB_DATA-1:0] data;
        int                 cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   ovr_cnt = 0;
    int   tmo_cnt = 0;
    int   start_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_alu_sequencer_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_sequencer #(
        .NB_DATA       (NB_DATA),
        .NB_OP         (NB_OP),
        .TIMEOUT_TICKS (TICKS)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    // Behavioural ALU
    always_comb begin
        case (bus.o_alu_op)
            OP_ADD:  bus.i_alu_result = bus.o_alu_data_a + bus.o_alu_data_b;
            OP_SUB:  bus.i_alu_result = bus.o_alu_data_a - bus.o_alu_data_b;
            OP_AND:  bus.i_alu_result = bus.o_alu_data_a & bus.o_alu_data_b;
            OP_OR:   bus.i_alu_result = bus.o_alu_data_a | bus.o_alu_data_b;
            OP_XOR:  bus.i_alu_result = bus.o_alu_data_a ^ bus.o_alu_data_b;
            OP_NOR:  bus.i_alu_result = ~(bus.o_alu_data_a | bus.o_alu_data_b);
            OP_SRA:  bus.i_alu_result = NB_DATA'($signed(bus.o_alu_data_a) >>> bus.o_alu_data_b);
            OP_SRL:  bus.i_alu_result = bus.o_alu_data_a >> bus.o_alu_data_b;
            default: bus.i_alu_result = '0;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and pulse counters
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_tx_start) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_start_unexpected: got start with data 0x%0h, required no start",
                             bus.o_tx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tx_data", int'(bus.o_tx_data), int'(e.data));
                    check("tx_start_cycle", cyc, e.cyc);
                end
            end
            if (bus.o_overrun) ovr_cnt++;
            if (bus.o_timeout) tmo_cnt++;
        end
    end

    task automatic rx_byte(input logic [NB_DATA-1:0] b, output int edge_n);
        @(negedge clk);
        bus.i_rx_data      = b;
        bus.i_rx_done_tick = 1'b1;
        edge_n             = cyc + 1;
        @(negedge clk);
        bus.i_rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [NB_DATA-1:0] a, input logic [NB_DATA-1:0] b,
                              input logic [NB_OP-1:0] op, input logic [NB_DATA-1:0] res);
        int   n;
        exp_t e;
        rx_byte(a, n);
        rx_byte(b, n);
        rx_byte(NB_DATA'(op), n);
        e.data = res;
        e.cyc  = n + 2;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_tx_start) break;
        end
        check(name, int'(k < 20), 1);
    endtask

    task automatic tx_done(input bit with_rx, input logic [NB_DATA-1:0] b);
        @(negedge clk);
        bus.i_tx_done_tick = 1'b1;
        if (with_rx) begin
            bus.i_rx_data      = b;
            bus.i_rx_done_tick = 1'b1;
        end
        @(negedge clk);
        bus.i_tx_done_tick = 1'b0;
        bus.i_rx_done_tick = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"},       int'(bus.o_alu_data_a), 0);
        check({tag, "_b"},       int'(bus.o_alu_data_b), 0);
        check({tag, "_op"},      int'(bus.o_alu_op), 0);
        check({tag, "_tx_data"}, int'(bus.o_tx_data), 0);
        check({tag, "_flags"},   int'({bus.o_tx_start, bus.o_busy, bus.o_overrun, bus.o_timeout}), 0);
    endtask

    // Directed stimulus
    initial begin
        int n;
        int s0;
        int o0;
        int t0;
        bus.i_rx_data      = '0;
        bus.i_rx_done_tick = 1'b0;
        bus.i_tx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // 1: ADD, latency checked by scoreboard
        send_frame(8'h05, 8'h03, OP_ADD, 8'h08);
        wait_start("t1_start_seen");
        repeat (3) @(negedge clk);
        check("t1_busy_in_tx", int'(bus.o_busy), 1);
        check("t1_tx_data_hold", int'(bus.o_tx_data), 8'h08);
        tx_done(1'b0, '0);
        check("t1_busy_after_done", int'(bus.o_busy), 0);

        // 2: NOR, then 3: overrun while transmitting
        send_frame(8'h0F, 8'h3C, OP_NOR, 8'hC0);
        wait_start("t2_start_seen");
        check("t2_busy_in_tx", int'(bus.o_busy), 1);
        o0 = ovr_cnt;
        rx_byte(8'hAA, n);
        @(negedge clk);
        check("t3_overrun_pulse", ovr_cnt, o0 + 1);
        check("t3_tx_data_kept", int'(bus.o_tx_data), 8'hC0);
        check("t3_a_kept", int'(bus.o_alu_data_a), 8'h0F);
        check("t2_busy_until_done", int'(bus.o_busy), 1);
        tx_done(1'b0, '0);
        check("t2_busy_after_done", int'(bus.o_busy), 0);
        send_frame(8'h01, 8'h01, OP_ADD, 8'h02);
        wait_start("t3_start_seen");
        tx_done(1'b0, '0);

        // 4: reset mid-frame
        rx_byte(8'h11, n);
        rx_byte(8'h22, n);
        check("t4_a_loaded", int'(bus.o_alu_data_a), 8'h11);
        check("t4_b_loaded", int'(bus.o_alu_data_b), 8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("t4_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h09, 8'h04, OP_SUB, 8'h05);
        wait_start("t4_start_seen");
        tx_done(1'b0, '0);

        // 5: rx_done and tx_done together
        send_frame(8'h33, 8'h0F, OP_AND, 8'h03);
        wait_start("t5_start_seen");
        o0 = ovr_cnt;
        tx_done(1'b1, 8'h55);
        check("t5_busy_after_done", int'(bus.o_busy), 0);
        s0 = start_cnt;
        @(negedge clk);
        check("t5_overrun_pulse", ovr_cnt, o0 + 1);
        check("t5_a_kept", int'(bus.o_alu_data_a), 8'h33);
        repeat (5) @(negedge clk);
        check("t5_no_second_start", start_cnt, s0);

        // Additional opcodes
        send_frame(8'hF0, 8'h3C, OP_OR, 8'hFC);
        wait_start("or_start_seen");
        tx_done(1'b0, '0);
        send_frame(8'h5A, 8'hFF, OP_XOR, 8'hA5);
        wait_start("xor_start_seen");
        tx_done(1'b0, '0);
        send_frame(8'h80, 8'h03, OP_SRL, 8'h10);
        wait_start("srl_start_seen");
        tx_done(1'b0, '0);

`ifdef UART_ALU_SEQ_TIMEOUT_EN
        // 6: frame abandoned after A
        t0 = tmo_cnt;
        rx_byte(8'h77, n);
        check("t6_busy_wait_b", int'(bus.o_busy), 1);
        repeat (20) @(negedge clk);
        check("t6_timeout_pulse", tmo_cnt, t0 + 1);
        check("t6_idle_after_timeout", int'(bus.o_busy), 0);
        check("t6_a_kept", int'(bus.o_alu_data_a), 8'h77);
`endif
        send_frame(8'h80, 8'h01, OP_SRA, 8'hC0);
        wait_start("t6_start_seen");
        tx_done(1'b0, '0);
`ifndef UART_ALU_SEQ_TIMEOUT_EN
        t0 = 0;
        check("no_timeout_pulses", tmo_cnt, t0);
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
